// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bit positions, control width and writeback FSM encoding.
package pipe_pkg;

   localparam int unsigned CTRL_W        = 11;
   localparam int unsigned CTRL_REGWRITE = 10;
   localparam int unsigned CTRL_MEMTOREG = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bitmap: bits are set at issue and cleared at writeback; set wins, register 0 never tracked.
module wb_scoreboard #(
   parameter int SIZE = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_set_en,
   input  logic [$clog2(SIZE)-1:0] i_set_idx,
   input  logic                    i_clr_en,
   input  logic [$clog2(SIZE)-1:0] i_clr_idx,
   output logic [SIZE-1:0]         o_busy
);

   logic [SIZE-1:0] r_busy;
   logic [SIZE-1:0] w_set;
   logic [SIZE-1:0] w_clr;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (i_set_en && (i_set_idx != '0)) w_set[i_set_idx] = 1'b1;
      if (i_clr_en) w_clr[i_clr_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_busy <= '0;
      else        r_busy <= (r_busy & ~w_clr) | w_set;
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, write-once FSM, result mux and hazard scoreboard.
// Optional retired-instruction counter is enabled by defining WB_RETIRE_COUNT_EN.
module wb_stage
   import pipe_pkg::*;
#(
   parameter int SIZE = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall,
   input  logic [SIZE-1:0]         data,
   input  logic [SIZE-1:0]         ALUresultMEM,
   input  logic [$clog2(SIZE)-1:0] writeRegMEM,
   input  logic [CTRL_W-1:0]       controlMEM,
   input  logic                    issueEn,
   input  logic [$clog2(SIZE)-1:0] issueReg,
   output logic                    regWriteEn,
   output logic [$clog2(SIZE)-1:0] regWriteAddr,
   output logic [SIZE-1:0]         regWriteData,
   output logic [SIZE-1:0]         busy
`ifdef WB_RETIRE_COUNT_EN
  ,output logic [SIZE-1:0]         retired
`endif
);

   logic [SIZE-1:0]         r_data;
   logic [SIZE-1:0]         r_alu;
   logic [$clog2(SIZE)-1:0] r_wreg;
   logic [CTRL_W-1:0]       r_ctrl;
   wb_state_t               r_state;
   wb_state_t               w_next;
   logic                    w_wr_en;
   logic                    w_ctrl_unused;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data <= '0;
         r_alu  <= '0;
         r_wreg <= '0;
         r_ctrl <= '0;
      end else if (!stall) begin
         r_data <= data;
         r_alu  <= ALUresultMEM;
         r_wreg <= writeRegMEM;
         r_ctrl <= controlMEM;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // WRITE lasts one cycle per capture; a stall parks it in HOLD so the strobe never repeats.
   always_comb begin
      w_next  = r_state;
      w_wr_en = 1'b0;
      if (!stall) begin
         w_next = controlMEM[CTRL_REGWRITE] ? WRITE : IDLE;
      end else if (r_state == WRITE) begin
         w_next = HOLD;
      end
      if ((r_state == WRITE) && (r_wreg != '0)) w_wr_en = 1'b1;
   end

   assign regWriteEn    = w_wr_en;
   assign regWriteAddr  = r_wreg;
   assign regWriteData  = r_ctrl[CTRL_MEMTOREG] ? r_data : r_alu;
   assign w_ctrl_unused = ^{r_ctrl[CTRL_W-1], r_ctrl[CTRL_MEMTOREG-1:0]};

   wb_scoreboard #(.SIZE(SIZE)) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_set_en  (issueEn),
      .i_set_idx (issueReg),
      .i_clr_en  (w_wr_en),
      .i_clr_idx (r_wreg),
      .o_busy    (busy)
   );

`ifdef WB_RETIRE_COUNT_EN
   localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};
   logic [SIZE-1:0] r_retired;

   always_ff @(posedge clk) begin
      if (!rst_n)                          r_retired <= '0;
      else if (!stall && (controlMEM != '0)) r_retired <= r_retired + ONE;
   end

   assign retired = r_retired;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
- REQ-001 SHALL have parameter SIZE, default 32: datapath width and register count; register index width is clog2(SIZE).
- REQ-002 SHALL have port clk  input  1  rising-edge clock driving the pipeline.
- REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
- REQ-004 SHALL have port stall  input  1  freeze MEM/WB register when high.
- REQ-005 SHALL have port data  input  SIZE  load data from the memory stage.
- REQ-006 SHALL have port ALUresultMEM  input  SIZE  ALU result carried through the memory stage.
- REQ-007 SHALL have port writeRegMEM  input  clog2(SIZE)  destination register from the memory stage.
- REQ-008 SHALL have port controlMEM  input  11  control bits from the memory stage.
- REQ-009 SHALL have port issueEn  input  1  ID issued a register-writing instruction this cycle.
- REQ-010 SHALL have port issueReg  input  clog2(SIZE)  destination register of the issued instruction.
- REQ-011 SHALL have port regWriteEn  output  1  register-file write strobe.
- REQ-012 SHALL have port regWriteAddr  output  clog2(SIZE)  register-file write address, also used as the forwarding tag.
- REQ-013 SHALL have port regWriteData  output  SIZE  register-file write data, also used as the forwarding value.
- REQ-014 SHALL have port busy  output  SIZE  per-register pending-write bitmap for ID hazard stalls.

Function
- REQ-015 SHALL capture data, ALUresultMEM, writeRegMEM and controlMEM into the MEM/WB register on a rising edge when stall=0, and SHALL hold that register when stall=1.
- REQ-016 SHALL take regWriteData from the captured data when CTRL_MEMTOREG=1, otherwise from the captured ALUresultMEM.
- REQ-017 SHALL drive regWriteAddr from the captured writeRegMEM.
- REQ-018 SHALL make outputs valid one cycle after MEM presents its inputs (latency 1).
- REQ-019 SHALL implement a state machine with states IDLE, WRITE and HOLD.
- REQ-020 SHALL, when stall=0, go to WRITE if captured CTRL_REGWRITE=1, otherwise to IDLE.
- REQ-021 SHALL, when stall=1, go from WRITE to HOLD and SHALL otherwise keep the current state.
- REQ-022 SHALL assert regWriteEn only in WRITE and only when regWriteAddr is not 0, so each instruction writes exactly once under any length of stall.
- REQ-023 SHALL set busy[issueReg] on issueEn=1, except that busy[0] SHALL never be set.
- REQ-024 SHALL clear busy[regWriteAddr] in every cycle in which regWriteEn=1.
- REQ-025 SHALL give set priority when a set and a clear hit the same register in the same cycle.

Reset
- REQ-026 SHALL, when rst_n=0 at a rising edge, set state to IDLE, clear the MEM/WB register and set busy to 0.
- REQ-027 SHALL hold regWriteEn=0, regWriteAddr=0 and regWriteData=0 during reset and in the first cycle after release.
- REQ-028 SHALL give reset priority over stall and issueEn.
- REQ-029 SHALL discard any write in flight when reset is asserted mid-operation; no write strobe is produced for it.

Configuration
- REQ-030 SHALL, when WB_RETIRE_COUNT_EN is defined, add output retired (SIZE bits).
- REQ-031 SHALL increment retired by 1 on every cycle in which the state enters WRITE or IDLE from a capture with nonzero controlMEM, SHALL wrap modulo 2^SIZE, and SHALL reset it to 0.
- REQ-032 SHALL neither have the retired port nor any counter logic when WB_RETIRE_COUNT_EN is undefined.

Structure
- REQ-033 SHALL place CTRL_REGWRITE=10, CTRL_MEMTOREG=9, the state encoding (IDLE=0, WRITE=1, HOLD=2) and the control width (11) in shared package pipe_pkg.
- REQ-034 SHALL place the busy bitmap in sub-module wb_scoreboard, with set/clear ports and the busy output.
- REQ-035 SHALL keep the MEM/WB register, the state machine and the result mux in wb_stage.

Verification
- REQ-036 SHALL cover ALU writeback: ALUresultMEM=0x0000_0005, writeRegMEM=8, REGWRITE=1, MEMTOREG=0 -> next cycle regWriteEn=1, addr=8, data=5.
- REQ-037 SHALL cover load writeback: data=0xDEAD_BEEF, ALUresultMEM=0x10, writeRegMEM=9, REGWRITE=1, MEMTOREG=1 -> regWriteData=0xDEAD_BEEF.
- REQ-038 SHALL cover register 0: writeRegMEM=0, REGWRITE=1 -> regWriteEn stays 0 and busy[0] stays 0.
- REQ-039 SHALL cover a stall: stall=1 for 3 cycles after a WRITE -> exactly one regWriteEn pulse, state HOLD, outputs frozen.
- REQ-040 SHALL cover the scoreboard: issueEn with reg 4 -> busy=0x10; then a writeback to reg 4 in the same cycle as issueEn with reg 4 -> busy[4] remains 1.
- REQ-041 SHALL cover reset mid-operation: rst_n=0 in a WRITE cycle with busy=0x30 -> next cycle busy=0, regWriteEn=0, retired=0 (WB_RETIRE_COUNT_EN defined).
